// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FIFO family.
// Defines the read-mode selector and the power-of-two check used at elaboration.
package fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sdpram_1clk.sv
// Single-clock simple dual-port RAM: synchronous write, combinational read.
// The array is deliberately left without reset so it maps onto plain storage.
module sdpram_1clk #(
    parameter int  Depth     = 8,
    parameter int  Width     = 4,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [Width-1:0]     wr_data,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [Width-1:0]     rd_data
);

    logic [Width-1:0] mem_r [Depth];

    // Write port: one entry per accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_chk.sv
// Elaboration-time parameter legality checks for sync_fifo.
// Contains no logic; an illegal configuration stops elaboration.
module sync_fifo_chk
    import fifo_pkg::*;
#(
    parameter int Depth          = 8,
    parameter int AlmostFullThr  = 7,
    parameter int AlmostEmptyThr = 1
) ();

    if (!is_pow2(Depth)) begin : g_bad_depth
        $error("sync_fifo: Depth must be a power of two and >= 2");
    end

    if ((AlmostFullThr < 1) || (AlmostFullThr > Depth)) begin : g_bad_af
        $error("sync_fifo: AlmostFullThr must be in 1..Depth");
    end

    if ((AlmostEmptyThr < 0) || (AlmostEmptyThr > Depth - 1)) begin : g_bad_ae
        $error("sync_fifo: AlmostEmptyThr must be in 0..Depth-1");
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, programmable almost flags, STD/FWFT read
// modes, synchronous flush and one-cycle overflow/underflow pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         Depth          = 8,
    parameter int         Width          = 4,
    parameter fifo_mode_e Mode           = FIFO_STD,
    parameter int         AlmostFullThr  = Depth - 1,
    parameter int         AlmostEmptyThr = 1,
    localparam int        PtrWidth       = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_wr_en,
    input  logic [Width-1:0]    i_wr_data,
    input  logic                i_rd_en,
    output logic [Width-1:0]    o_rd_data,
    output logic                o_rd_valid,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_almost_full,
    output logic                o_almost_empty,
    output logic [PtrWidth:0]   o_count,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam logic [PtrWidth:0]   DEPTH_C    = (PtrWidth + 1)'(Depth);
    localparam logic [PtrWidth:0]   AF_THR_C   = (PtrWidth + 1)'(AlmostFullThr);
    localparam logic [PtrWidth:0]   AE_THR_C   = (PtrWidth + 1)'(AlmostEmptyThr);
    localparam logic [PtrWidth:0]   CNT_ZERO_C = (PtrWidth + 1)'(0);
    localparam logic [PtrWidth:0]   CNT_ONE_C  = (PtrWidth + 1)'(1);
    localparam logic [PtrWidth-1:0] PTR_ZERO_C = PtrWidth'(0);
    localparam logic [PtrWidth-1:0] PTR_ONE_C  = PtrWidth'(1);

    logic [PtrWidth-1:0] wr_ptr_r;
    logic [PtrWidth-1:0] rd_ptr_r;
    logic [PtrWidth:0]   count_r;
    logic [PtrWidth:0]   count_nxt_s;
    logic                overflow_r;
    logic                underflow_r;
    logic                full_s;
    logic                empty_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic [Width-1:0]    mem_rd_data_s;

    sync_fifo_chk #(
        .Depth          (Depth),
        .AlmostFullThr  (AlmostFullThr),
        .AlmostEmptyThr (AlmostEmptyThr)
    ) u_chk ();

    sdpram_1clk #(
        .Depth (Depth),
        .Width (Width)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (i_wr_data),
        .rd_addr (rd_ptr_r),
        .rd_data (mem_rd_data_s)
    );

    // Flags come only from the registered count, never from the request inputs.
    assign full_s         = (count_r == DEPTH_C);
    assign empty_s        = (count_r == CNT_ZERO_C);
    assign o_full         = full_s;
    assign o_empty        = empty_s;
    assign o_almost_full  = (count_r >= AF_THR_C);
    assign o_almost_empty = (count_r <= AE_THR_C);
    assign o_count        = count_r;
    assign o_overflow     = overflow_r;
    assign o_underflow    = underflow_r;

    // Acceptance: full/empty is judged on the current count, so a same-cycle
    // opposite operation never rescues a rejected request.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (!i_clr) begin
            wr_acc_s = i_wr_en & ~full_s;
            rd_acc_s = i_rd_en & ~empty_s;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
    end

    // Next fill level from the pair of accepted operations.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and rejection pulses; flush wins over any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            count_r     <= CNT_ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (i_clr) begin
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            count_r     <= CNT_ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= i_wr_en & full_s;
            underflow_r <= i_rd_en & empty_s;
        end
    end

    if (Mode == FIFO_STD) begin : g_std
        logic [Width-1:0] rd_data_r;
        logic             rd_valid_r;

        // Registered read port: data captured on accept, valid is a one-cycle pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_r  <= {Width{1'b0}};
                rd_valid_r <= 1'b0;
            end else if (i_clr) begin
                rd_valid_r <= 1'b0;
            end else begin
                rd_valid_r <= rd_acc_s;
                if (rd_acc_s) begin
                    rd_data_r <= mem_rd_data_s;
                end
            end
        end

        assign o_rd_data  = rd_data_r;
        assign o_rd_valid = rd_valid_r;
    end else begin : g_fwft
        // Head entry is shown directly; it is meaningful only while not empty.
        assign o_rd_data  = mem_rd_data_s;
        assign o_rd_valid = ~empty_s;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo: an STD and an FWFT instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_clr;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             i_rd_en;

    logic [WIDTH-1:0] s_rd_data, f_rd_data;
    logic             s_rd_valid, f_rd_valid;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]       s_count, f_count;

    sync_fifo #(.Depth(DEPTH), .Width(WIDTH), .Mode(FIFO_STD)) dut_std (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_rd_en(i_rd_en), .o_rd_data(s_rd_data),
        .o_rd_valid(s_rd_valid), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    sync_fifo #(.Depth(DEPTH), .Width(WIDTH), .Mode(FIFO_FWFT)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_rd_en(i_rd_en), .o_rd_data(f_rd_data),
        .o_rd_valid(f_rd_valid), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, expected STD read data as a scoreboard.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               e_ovf, e_unf, e_rdv;
    bit               chk_en;
    int               n_cmp = 0;
    int               n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus, issued at a falling edge; the model advances to
    // the state the DUT should hold after the coming rising edge.
    task automatic cyc(input bit wr, input logic [WIDTH-1:0] wd, input bit rd, input bit clr);
        int sz;
        sz        = mq.size();
        i_wr_en   = wr;
        i_wr_data = wd;
        i_rd_en   = rd;
        i_clr     = clr;
        e_ovf     = wr && !clr && (sz == DEPTH);
        e_unf     = rd && !clr && (sz == 0);
        e_rdv     = 1'b0;
        if (clr) begin
            mq.delete();
        end else begin
            if (rd && sz > 0) begin
                exp_q.push_back(mq.pop_front());
                e_rdv = 1'b1;
            end
            if (wr && sz < DEPTH) mq.push_back(wd);
        end
        @(negedge clk);
    endtask

    // Monitor: samples shortly after each rising edge, compares against the model.
    always @(posedge clk) begin
        #2;
        if (rst_n && chk_en) begin
            chk("std_count", s_count, mq.size());
            chk("std_full", s_full, mq.size() == DEPTH);
            chk("std_empty", s_empty, mq.size() == 0);
            chk("std_afull", s_af, mq.size() >= DEPTH - 1);
            chk("std_aempty", s_ae, mq.size() <= 1);
            chk("std_overflow", s_ovf, e_ovf);
            chk("std_underflow", s_unf, e_unf);
            chk("std_rd_valid", s_rd_valid, e_rdv);
            if (s_rd_valid) begin
                if (exp_q.size() == 0) chk("std_spurious_read", 1, 0);
                else chk("std_rd_data", s_rd_data, exp_q.pop_front());
            end
            chk("fwft_count", f_count, mq.size());
            chk("fwft_overflow", f_ovf, e_ovf);
            chk("fwft_underflow", f_unf, e_unf);
            chk("fwft_rd_valid", f_rd_valid, mq.size() > 0);
            if (mq.size() > 0) chk("fwft_head", f_rd_data, mq[0]);
        end
    end

    task automatic chk_reset_state();
        chk("rst_std_rd_data", s_rd_data, 0);
        chk("rst_std_rd_valid", s_rd_valid, 0);
        chk("rst_std_empty", s_empty, 1);
        chk("rst_std_aempty", s_ae, 1);
        chk("rst_std_full", s_full, 0);
        chk("rst_std_afull", s_af, 0);
        chk("rst_std_count", s_count, 0);
        chk("rst_std_ovf", s_ovf, 0);
        chk("rst_std_unf", s_unf, 0);
        chk("rst_fwft_valid", f_rd_valid, 0);
        chk("rst_fwft_count", f_count, 0);
    endtask

    initial begin
        chk_en = 1'b0;
        rst_n  = 1'b0;
        i_clr = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill 1..8, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);

        // Simultaneous read+write at count 3, then at count 0.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 10), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 3), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h5, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);

        // Wrap-around with interleaved traffic.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b0);
        end

        // Flush at count 5 together with a write, then with a read.
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 1), 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h7, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);

        // Randomised traffic in phases biased towards filling, draining and balance.
        for (int ph = 0; ph < 6; ph++) begin
            int wr_pct;
            wr_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 80; i++) begin
                cyc($urandom_range(0, 99) < wr_pct,
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < (100 - wr_pct),
                    $urandom_range(0, 99) < 3);
            end
        end

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 2), 1'b1, 1'b0);
        cyc(1'b1, 4'hC, 1'b0, 1'b0);
        i_wr_en = 1'b1;
        i_wr_data = 4'hD;
        chk_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        mq.delete();
        exp_q.delete();
        e_ovf = 1'b0; e_unf = 1'b0; e_rdv = 1'b0;
        i_wr_en = 1'b0; i_rd_en = 1'b0; i_clr = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cyc(1'b1, 4'h6, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
